// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC measurement scheduler.
package tdc_pkg;

  localparam int DATA_W_DEF   = 40;
  localparam int GUARD_CYCLES = 16;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_LAUNCH = 2'd1,
    T_WAITB  = 2'd2,
    T_WAITD  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tdc_meas_scheduler_sync_fifo.sv
// Flop-based FIFO; head always presents the oldest entry, level tracked independently of pointers.
module tdc_meas_scheduler_sync_fifo
  import tdc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              push_ok;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  // A push at full is only accepted when the same cycle frees a slot.
  assign push_ok = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/tdc_meas_scheduler.sv
// Arms tdc_core with holdoff and timeout abort, buffers results, and feeds uart_tx one word at a time.
module tdc_meas_scheduler
  import tdc_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = 8,
  parameter int HOLDOFF       = 16,
  parameter int TIMEOUT       = 2000000,
  parameter int STALL_ON_FULL = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       meas_data,
  input  logic                    meas_valid,
  input  logic                    tdc_idle,
  output logic                    arm,
  output logic                    tdc_abort,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [15:0]             drop_count,
  output logic [15:0]             timeout_count
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    GUARD_LAST = 4'(GUARD_CYCLES - 1);

  tx_state_e         state_q, state_d;
  logic [3:0]        guard_q, guard_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              arm_q, arm_d;
  logic              abort_q, abort_d;
  logic [15:0]       tocnt_q, tocnt_d;
  logic [15:0]       dropcnt_q, dropcnt_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              stall, to_hit;

  tdc_meas_scheduler_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (meas_valid),
    .pop   (fifo_pop),
    .din   (meas_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign arm           = arm_q;
  assign tdc_abort     = abort_q;
  assign tx_data       = tx_data_q;
  assign drop_count    = dropcnt_q;
  assign timeout_count = tocnt_q;

  assign stall  = (STALL_ON_FULL != 0) && fifo_full;
  // A result arriving on the final timeout cycle beats the abort.
  assign to_hit = ~tdc_idle & (tcnt_q == TO_LAST) & ~meas_valid;

  // TX handshake; a word is only popped once uart_tx is free to take it.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    tx_start  = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (~fifo_empty & ~tx_busy) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_head;
          state_d   = T_LAUNCH;
        end
      end
      T_LAUNCH: begin
        tx_start = 1'b1;
        guard_d  = '0;
        state_d  = T_WAITB;
      end
      T_WAITB: begin
        if (tx_busy) begin
          state_d = T_WAITD;
        end else if (guard_q == GUARD_LAST) begin
          state_d = T_IDLE;
        end else begin
          guard_d = guard_q + 4'd1;
        end
      end
      T_WAITD: begin
        if (~tx_busy) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  always_comb begin
    hold_d    = hold_q;
    tcnt_d    = tcnt_q;
    tocnt_d   = tocnt_q;
    dropcnt_d = dropcnt_q;
    abort_d   = to_hit;
    arm_d     = enable & tdc_idle & (hold_q == '0) & ~stall;

    if (tdc_idle || (tcnt_q == TO_LAST)) tcnt_d = '0;
    else                                 tcnt_d = tcnt_q + TW'(1);

    if (to_hit && (tocnt_q != 16'hFFFF)) tocnt_d = tocnt_q + 16'd1;

    if (meas_valid | to_hit)  hold_d = HOLD_LOAD;
    else if (hold_q != '0)    hold_d = hold_q - HW'(1);

    if (meas_valid && fifo_full && !fifo_pop && (dropcnt_q != 16'hFFFF))
      dropcnt_d = dropcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= T_IDLE;
      guard_q   <= '0;
      tx_data_q <= '0;
      hold_q    <= '0;
      tcnt_q    <= '0;
      arm_q     <= 1'b0;
      abort_q   <= 1'b0;
      tocnt_q   <= '0;
      dropcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      hold_q    <= hold_d;
      tcnt_q    <= tcnt_d;
      arm_q     <= arm_d;
      abort_q   <= abort_d;
      tocnt_q   <= tocnt_d;
      dropcnt_q <= dropcnt_d;
    end
  end

endmodule

// File: tb/tb_tdc_meas_scheduler.sv
// Directed bench for tdc_meas_scheduler: a drop-on-full instance and a stall-on-full instance share stimulus.
`timescale 1ns/1ps
module tb_tdc_meas_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, meas_valid, tdc_idle, tx_busy;
  logic [39:0] meas_data;

  logic        arm, tdc_abort, tx_start;
  logic [39:0] tx_data;
  logic [3:0]  fifo_level;
  logic [15:0] drop_count, timeout_count;

  logic        arm_s, tdc_abort_s, tx_start_s;
  logic [39:0] tx_data_s;
  logic [3:0]  fifo_level_s;
  logic [15:0] drop_count_s, timeout_count_s;

  int n_assert = 0;
  int n_fail   = 0;

  logic [39:0] dv [10] = '{40'hA0_0000_0001, 40'hA1_0000_0002, 40'hA2_0000_0003, 40'hA3_0000_0004,
                           40'hA4_0000_0005, 40'hA5_0000_0006, 40'hA6_0000_0007, 40'hA7_0000_0008,
                           40'hB8_1234_5678, 40'hC9_8765_4321};

  tdc_meas_scheduler #(.DATA_W(40), .DEPTH(8), .HOLDOFF(16), .TIMEOUT(40), .STALL_ON_FULL(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .meas_data(meas_data), .meas_valid(meas_valid),
    .tdc_idle(tdc_idle), .arm(arm), .tdc_abort(tdc_abort), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .fifo_level(fifo_level), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  tdc_meas_scheduler #(.DATA_W(40), .DEPTH(8), .HOLDOFF(16), .TIMEOUT(40), .STALL_ON_FULL(1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .meas_data(meas_data), .meas_valid(meas_valid),
    .tdc_idle(tdc_idle), .arm(arm_s), .tdc_abort(tdc_abort_s), .tx_data(tx_data_s), .tx_start(tx_start_s),
    .tx_busy(tx_busy), .fifo_level(fifo_level_s), .drop_count(drop_count_s), .timeout_count(timeout_count_s)
  );

  always #2.5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays uart_tx: waits for a launch, checks the word, stays busy a few cycles, then frees up.
  task automatic respond(input logic [39:0] exp);
    int n = 0;
    while (tx_start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("tx_start_seen", {63'd0, tx_start}, 64'd1);
    chk("tx_data", {24'd0, tx_data}, {24'd0, exp});
    tx_busy = 1'b1;
    repeat (3) step();
    chk("tx_data_stable", {24'd0, tx_data}, {24'd0, exp});
    chk("tx_start_single", {63'd0, tx_start}, 64'd0);
    tx_busy = 1'b0;
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; meas_valid = 1'b0; tdc_idle = 1'b1; tx_busy = 1'b0; meas_data = '0;
    step(); step();
    chk("rst_arm", {63'd0, arm}, 64'd0);
    chk("rst_tx_start", {63'd0, tx_start}, 64'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 64'd0);
    chk("rst_level", {60'd0, fifo_level}, 64'd0);
    chk("rst_abort", {63'd0, tdc_abort}, 64'd0);
    chk("rst_drops", {48'd0, drop_count}, 64'd0);
    chk("rst_timeouts", {48'd0, timeout_count}, 64'd0);
    rst = 1'b0; enable = 1'b1;
    step();
    chk("arm_after_rst", {63'd0, arm}, 64'd1);

    // Single measurement into an empty FIFO
    meas_data = 40'h00_0000_1234; meas_valid = 1'b1; tdc_idle = 1'b0;
    step();
    meas_valid = 1'b0; tdc_idle = 1'b1;
    chk("t1_level", {60'd0, fifo_level}, 64'd1);
    chk("t1_start_p1", {63'd0, tx_start}, 64'd0);
    chk("t1_arm_p1", {63'd0, arm}, 64'd0);
    step();
    chk("t1_start_p2", {63'd0, tx_start}, 64'd1);
    respond(40'h00_0000_1234);
    repeat (11) step();
    chk("t1_arm_p17", {63'd0, arm}, 64'd0);
    step();
    chk("t1_arm_p18", {63'd0, arm}, 64'd1);

    // Burst into a busy transmitter, then overflow
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      meas_data = dv[i]; meas_valid = 1'b1;
      step();
    end
    meas_valid = 1'b0;
    chk("t2_level8", {60'd0, fifo_level}, 64'd8);
    chk("t2_drop0", {48'd0, drop_count}, 64'd0);
    chk("t2_no_start", {63'd0, tx_start}, 64'd0);
    meas_data = 40'hDE_ADBE_EF00; meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
    chk("t2_drop1", {48'd0, drop_count}, 64'd1);
    chk("t2_level_still8", {60'd0, fifo_level}, 64'd8);
    repeat (17) step();
    chk("t5_arm_nostall", {63'd0, arm}, 64'd1);
    chk("t5_arm_stall_full", {63'd0, arm_s}, 64'd0);

    // First pop releases the stalled arm; then push while full coincides with a pop
    tx_busy = 1'b0;
    step();
    chk("t5_start", {63'd0, tx_start}, 64'd1);
    chk("t5_data0", {24'd0, tx_data}, {24'd0, dv[0]});
    chk("t5_level7", {60'd0, fifo_level}, 64'd7);
    chk("t5_arm_stall_popedge", {63'd0, arm_s}, 64'd0);
    tx_busy = 1'b1; meas_data = dv[8]; meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
    chk("t5_arm_stall_after_pop", {63'd0, arm_s}, 64'd1);
    chk("t5_level8", {60'd0, fifo_level}, 64'd8);
    step();
    tx_busy = 1'b0;
    step();
    meas_data = dv[9]; meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
    chk("t3_start", {63'd0, tx_start}, 64'd1);
    chk("t3_data1", {24'd0, tx_data}, {24'd0, dv[1]});
    chk("t3_level8", {60'd0, fifo_level}, 64'd8);
    chk("t3_drop_unchanged", {48'd0, drop_count}, 64'd1);
    for (int i = 1; i < 10; i++) respond(dv[i]);
    chk("t2_drained", {60'd0, fifo_level}, 64'd0);

    // Stuck TDC: timeout abort and holdoff afterwards
    tdc_idle = 1'b0;
    n = 0;
    while (tdc_abort !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    tdc_idle = 1'b1;
    chk("t4_abort_seen", {63'd0, tdc_abort}, 64'd1);
    chk("t4_abort_cycle", 64'(n), 64'd40);
    chk("t4_timeouts", {48'd0, timeout_count}, 64'd1);
    chk("t4_arm_low", {63'd0, arm}, 64'd0);
    step();
    chk("t4_abort_pulse", {63'd0, tdc_abort}, 64'd0);
    repeat (15) step();
    chk("t4_arm_holdoff", {63'd0, arm}, 64'd0);
    step();
    chk("t4_arm_back", {63'd0, arm}, 64'd1);

    // Reset during T_WAITD with five words queued
    for (int i = 0; i < 6; i++) begin
      meas_data = dv[i]; meas_valid = 1'b1;
      if (i == 2) begin
        chk("t6_start", {63'd0, tx_start}, 64'd1);
        tx_busy = 1'b1;
      end
      step();
    end
    meas_valid = 1'b0;
    chk("t6_level5", {60'd0, fifo_level}, 64'd5);
    chk("t6_data0", {24'd0, tx_data}, {24'd0, dv[0]});
    rst = 1'b1;
    step();
    chk("t6_arm", {63'd0, arm}, 64'd0);
    chk("t6_tx_data", {24'd0, tx_data}, 64'd0);
    chk("t6_level", {60'd0, fifo_level}, 64'd0);
    chk("t6_drops", {48'd0, drop_count}, 64'd0);
    chk("t6_timeouts", {48'd0, timeout_count}, 64'd0);
    chk("t6_tx_start", {63'd0, tx_start}, 64'd0);
    rst = 1'b0; tx_busy = 1'b0;
    step();
    chk("t6_arm_recovers", {63'd0, arm}, 64'd1);
    step(); step();
    chk("t6_no_launch", {63'd0, tx_start}, 64'd0);
    chk("t6_level_empty", {60'd0, fifo_level}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
